mem_responder: RTL and testbench

//  Memory-side responder for the CPU RAM interface (RAMaddr/RAMin/RAMout/we/re/be).

---
 rtl/mem_pkg.sv | 16 +
 rtl/mem_responder_page_table.sv | 19 +
 rtl/mem_responder.sv | 112 +++++++++++
 tb/tb_mem_responder.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared FSM encoding and page-table geometry helpers for mem_responder
package mem_pkg;
  typedef enum logic [2:0] {IDLE, CHK, B0, B1, DONE} state_t;
  function automatic int vpn_w(int page_bits);
    return 16 - page_bits;
  endfunction
  function automatic int ppn_w(int pa_w, int page_bits);
    return pa_w - page_bits;
  endfunction
  function automatic int pte_v(int ppn);
    return ppn + 1;
  endfunction
  function automatic int pte_w(int ppn);
    return ppn;
  endfunction
endpackage

// File: rtl/mem_responder_page_table.sv
// page_table: VPN-indexed PTE register file, sync write, async read, clears to invalid
module page_table #(
  parameter int IW = 5,
  parameter int DW = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [IW-1:0] widx,
  input  logic [DW-1:0] wdata,
  input  logic [IW-1:0] ridx,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] ent [2**IW];
  always_ff @(posedge clk)
    if (reset) for (int i = 0; i < 2**IW; i++) ent[i] <= '0;
    else if (we) ent[widx] <= wdata;
  assign rdata = ent[ridx];
endmodule

// File: rtl/mem_responder.sv
// mem_responder: paged CPU RAM port serialised onto an 8-bit SRAM with wait states
module mem_responder
  import mem_pkg::*;
#(
  parameter int PA_W      = 16,
  parameter int PAGE_BITS = 11,
  parameter int WAIT_CYC  = 1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [15:0]                            RAMaddr,
  input  logic [15:0]                            RAMin,
  input  logic                                   we,
  input  logic                                   re,
  input  logic                                   be,
  input  logic                                   paging_en,
  input  logic                                   pt_we,
  input  logic [vpn_w(PAGE_BITS)-1:0]            pt_idx,
  input  logic [ppn_w(PA_W,PAGE_BITS)+1:0]       pt_data,
  output logic [15:0]                            RAMout,
  output logic                                   rdy,
  output logic                                   page_fault,
  output logic [15:0]                            fault_addr,
  output logic [PA_W-1:0]                        sram_addr,
  output logic [7:0]                             sram_dout,
  input  logic [7:0]                             sram_din,
  output logic                                   sram_we,
  output logic                                   sram_oe
);
  localparam int VPN = vpn_w(PAGE_BITS);
  localparam int PPN = ppn_w(PA_W, PAGE_BITS);
  localparam int CW  = $clog2(WAIT_CYC + 2);
  state_t        state;
  logic          armed, is_byte, is_wr, fault;
  logic [15:0]   addr, wdata;
  logic [7:0]    lo;
  logic [CW-1:0] cnt;
  logic [PPN+1:0] pte;
  logic [PA_W-1:0] tpa;
  page_table #(.IW(VPN), .DW(PPN + 2)) u_pt (
    .clk(clk), .reset(reset), .we(pt_we), .widx(pt_idx), .wdata(pt_data),
    .ridx(addr[15:PAGE_BITS]), .rdata(pte)
  );
  always_comb begin
    fault = paging_en && (!pte[pte_v(PPN)] || (is_wr && !pte[pte_w(PPN)]));
    tpa   = paging_en ? {pte[PPN-1:0], addr[PAGE_BITS-1:0]} : PA_W'(addr);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      armed      <= 1'b1;
      is_byte    <= 1'b0;
      is_wr      <= 1'b0;
      addr       <= '0;
      wdata      <= '0;
      lo         <= '0;
      cnt        <= '0;
      RAMout     <= '0;
      rdy        <= 1'b0;
      page_fault <= 1'b0;
      fault_addr <= '0;
      sram_addr  <= '0;
      sram_dout  <= '0;
      sram_we    <= 1'b0;
      sram_oe    <= 1'b0;
    end else begin
      rdy        <= 1'b0;
      page_fault <= 1'b0;
      if (!re && !we) armed <= 1'b1;
      case (state)
        IDLE: if (armed && (re || we)) begin
          addr    <= RAMaddr;
          wdata   <= RAMin;
          is_byte <= be;
          is_wr   <= we;
          armed   <= 1'b0;
          state   <= CHK;
        end
        CHK: if (fault) begin
          state      <= DONE;
          rdy        <= 1'b1;
          page_fault <= 1'b1;
          fault_addr <= addr;
        end else begin
          state     <= B0;
          sram_addr <= is_byte ? tpa : {tpa[PA_W-1:1], 1'b0};
          sram_dout <= wdata[7:0];
          sram_we   <= is_wr;
          sram_oe   <= !is_wr;
          cnt       <= '0;
        end
        B0, B1: if (cnt == CW'(WAIT_CYC)) begin
          cnt <= '0;
          if (state == B0) lo <= sram_din;
          if (state == B0 && !is_byte) begin
            state     <= B1;
            sram_addr <= sram_addr | PA_W'(1);
            sram_dout <= wdata[15:8];
          end else begin
            state   <= DONE;
            rdy     <= 1'b1;
            sram_we <= 1'b0;
            sram_oe <= 1'b0;
            if (!is_wr) RAMout <= is_byte ? {8'h00, sram_din} : {sram_din, lo};
          end
        end else cnt <= cnt + CW'(1);
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed checks of translation, byte serialisation, faults and reset abort
module tb_mem_responder;
  logic        clk = 0, reset = 1;
  logic [15:0] RAMaddr = 0, RAMin = 0;
  logic        we = 0, re = 0, be = 0, paging_en = 0, pt_we = 0;
  logic [4:0]  pt_idx = 0;
  logic [6:0]  pt_data = 0;
  logic [15:0] RAMout, fault_addr, sram_addr;
  logic        rdy, page_fault, sram_we, sram_oe;
  logic [7:0]  sram_dout, sram_din;
  logic [7:0]  mem [0:65535];
  int checks = 0, errors = 0;
  int rdy_cnt = 0, oe_cyc = 0, we_cyc = 0;
  logic [15:0] alog [$];
  logic prev_s = 0;
  logic [15:0] prev_a = 0;
  int lat;
  logic pf;
  mem_responder #(.PA_W(16), .PAGE_BITS(11), .WAIT_CYC(1)) dut (
    .clk(clk), .reset(reset), .RAMaddr(RAMaddr), .RAMin(RAMin), .we(we), .re(re), .be(be),
    .paging_en(paging_en), .pt_we(pt_we), .pt_idx(pt_idx), .pt_data(pt_data),
    .RAMout(RAMout), .rdy(rdy), .page_fault(page_fault), .fault_addr(fault_addr),
    .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_din(sram_din),
    .sram_we(sram_we), .sram_oe(sram_oe)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0] ^ a[15:8];
  endfunction
  always @(posedge clk)
    if (reset) for (int i = 0; i < 65536; i++) mem[i] = pat(i[15:0]);
    else if (sram_we) mem[sram_addr] = sram_dout;
  assign sram_din = mem[sram_addr];
  always @(negedge clk) begin
    if (rdy) rdy_cnt++;
    if (sram_oe) oe_cyc++;
    if (sram_we) we_cyc++;
    if ((sram_oe || sram_we) && (!prev_s || sram_addr != prev_a)) alog.push_back(sram_addr);
    prev_s = sram_oe || sram_we;
    prev_a = sram_addr;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic clr();
    rdy_cnt = 0; oe_cyc = 0; we_cyc = 0; alog.delete();
  endtask
  task automatic xfer(input logic w, input logic r, input logic b, input logic [15:0] a,
                      input logic [15:0] d, output int l, output logic f);
    @(negedge clk);
    clr();
    RAMaddr = a; RAMin = d; we = w; re = r; be = b;
    @(negedge clk);
    re = 0; we = 0;
    l = 0; f = 0;
    for (int k = 0; k < 40; k++) begin
      if (rdy) begin l = k + 1; f = page_fault; break; end
      @(negedge clk);
    end
  endtask
  task automatic ptw(input logic [4:0] i, input logic [6:0] d);
    @(negedge clk);
    pt_we = 1; pt_idx = i; pt_data = d;
    @(negedge clk);
    pt_we = 0;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_rdy", rdy, 0);
    chk("rst_pf", page_fault, 0);
    chk("rst_out", RAMout, 0);
    chk("rst_strobe", {sram_we, sram_oe}, 0);
    chk("rst_addr", sram_addr, 0);
    reset = 0;
    xfer(1, 0, 0, 16'h0102, 16'hBEEF, lat, pf);
    chk("t1_lat", lat, 6);
    chk("t1_lo", mem[16'h0102], 8'hEF);
    chk("t1_hi", mem[16'h0103], 8'hBE);
    chk("t1_wecyc", we_cyc, 4);
    chk("t1_nlog", alog.size(), 2);
    if (alog.size() == 2) begin
      chk("t1_a0", alog[0], 16'h0102);
      chk("t1_a1", alog[1], 16'h0103);
    end
    xfer(0, 1, 0, 16'h0102, 0, lat, pf);
    chk("t2_lat", lat, 6);
    chk("t2_word", RAMout, 16'hBEEF);
    xfer(0, 1, 1, 16'h0103, 0, lat, pf);
    chk("t2_blat", lat, 4);
    chk("t2_byte", RAMout, 16'h00BE);
    chk("t2_oecyc", oe_cyc, 2);
    ptw(1, 7'b11_00011);
    paging_en = 1;
    xfer(0, 1, 0, 16'h0804, 0, lat, pf);
    chk("t3_lat", lat, 6);
    chk("t3_nlog", alog.size(), 2);
    if (alog.size() == 2) begin
      chk("t3_a0", alog[0], 16'h1804);
      chk("t3_a1", alog[1], 16'h1805);
    end
    chk("t3_data", RAMout, 16'h1D1C);
    chk("t3_pf", pf, 0);
    xfer(0, 1, 0, 16'h1000, 0, lat, pf);
    chk("t4_lat", lat, 2);
    chk("t4_pf", pf, 1);
    chk("t4_faddr", fault_addr, 16'h1000);
    chk("t4_oecyc", oe_cyc, 0);
    chk("t4_out", RAMout, 16'h1D1C);
    ptw(1, 7'b10_00011);
    xfer(1, 0, 0, 16'h0800, 16'h1234, lat, pf);
    chk("t5_lat", lat, 2);
    chk("t5_pf", pf, 1);
    chk("t5_wecyc", we_cyc, 0);
    chk("t5_faddr", fault_addr, 16'h0800);
    xfer(0, 1, 0, 16'h0800, 0, lat, pf);
    chk("t5_rlat", lat, 6);
    chk("t5_rpf", pf, 0);
    chk("t5_rdata", RAMout, 16'h1918);
    @(negedge clk);
    clr();
    RAMaddr = 16'h0804; be = 1; re = 1;
    repeat (16) @(negedge clk);
    chk("t6_rdycnt", rdy_cnt, 1);
    chk("t6_oecyc", oe_cyc, 2);
    chk("t6_data", RAMout, 16'h001C);
    re = 0;
    repeat (3) @(negedge clk);
    chk("t6_idle", rdy_cnt, 1);
    paging_en = 0;
    @(negedge clk);
    clr();
    RAMaddr = 16'h0102; be = 0; re = 1;
    @(negedge clk);
    re = 0;
    lat = 0;
    for (int k = 0; k < 20; k++) begin
      if (sram_oe && sram_addr == 16'h0103) begin lat = 1; break; end
      @(negedge clk);
    end
    chk("t6_inb1", lat, 1);
    reset = 1;
    @(posedge clk);
    #1;
    chk("t6_rststrobe", {sram_we, sram_oe}, 0);
    @(negedge clk);
    reset = 0;
    clr();
    repeat (10) @(negedge clk);
    chk("t6_nordy", rdy_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
